// File: rtl/assert_event_collector.sv
// Collects assertion-monitor fire pulses into sticky per-source state.
// Fires are serialised into an event FIFO, and violations are counted with a stop threshold.
module assert_event_collector #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STOP_THRESH = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NUM_SRC-1:0]         fire,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_SRC)-1:0] evt_id,
    output logic [31:0]                evt_cycle,
    output logic [NUM_SRC-1:0]         pending,
    output logic [15:0]                total_count,
    output logic                       overflow,
    output logic                       stop_req
);

    localparam int unsigned ID_W  = $clog2(NUM_SRC);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned POP_W = $clog2(NUM_SRC + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      THRESH   = 16'(STOP_THRESH);

    logic [31:0]        counter_q, counter_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] unq_q, unq_d;
    logic [15:0]        total_q, total_d;
    logic               ovf_q, ovf_d;
    logic               stop_q, stop_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ID_W-1:0]    mem_id_q [FIFO_DEPTH];
    logic [ID_W-1:0]    mem_id_d [FIFO_DEPTH];
    logic [31:0]        mem_cyc_q [FIFO_DEPTH];
    logic [31:0]        mem_cyc_d [FIFO_DEPTH];

    logic [NUM_SRC-1:0] fire_acc;
    logic [NUM_SRC-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [POP_W-1:0]   fire_pop;
    logic [16:0]        total_sum;
    logic [15:0]        total_sat;
    logic               full;
    logic               push;
    logic               pop;

    // Lowest-index unqueued source wins the single enqueue slot, unless the FIFO is full.
    always_comb begin
        fire_acc = fire & {NUM_SRC{enable}};
        full     = (count_q == FULL_CNT);
        grant    = full ? '0 : (unq_q & (~unq_q + NUM_SRC'(1)));
        push     = |grant;
        pop      = (count_q != '0) & evt_ready;
        grant_id = '0;
        fire_pop = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
            end
            fire_pop = fire_pop + POP_W'(fire_acc[i]);
        end
        total_sum = 17'(total_q) + 17'(fire_pop);
        total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end

    // Next state; clear discards same-cycle fires and flushes the FIFO but leaves the counter running.
    always_comb begin
        counter_d = counter_q + 32'd1;
        pending_d = pending_q;
        unq_d     = unq_q;
        total_d   = total_q;
        ovf_d     = ovf_q;
        stop_d    = stop_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_id_d  = mem_id_q;
        mem_cyc_d = mem_cyc_q;

        if (clear) begin
            pending_d = '0;
            unq_d     = '0;
            total_d   = '0;
            ovf_d     = 1'b0;
            stop_d    = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            pending_d = pending_q | fire_acc;
            unq_d     = (unq_q & ~grant) | fire_acc;
            ovf_d     = ovf_q | (|(fire_acc & unq_q & ~grant));
            total_d   = total_sat;
            stop_d    = stop_q | (total_sat >= THRESH);
            if (push) begin
                mem_id_d[wr_ptr_q]  = grant_id;
                mem_cyc_d[wr_ptr_q] = counter_q;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            counter_q <= '0;
            pending_q <= '0;
            unq_q     <= '0;
            total_q   <= '0;
            ovf_q     <= 1'b0;
            stop_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_id_q[i]  <= '0;
                mem_cyc_q[i] <= '0;
            end
        end else begin
            counter_q <= counter_d;
            pending_q <= pending_d;
            unq_q     <= unq_d;
            total_q   <= total_d;
            ovf_q     <= ovf_d;
            stop_q    <= stop_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_id_q  <= mem_id_d;
            mem_cyc_q <= mem_cyc_d;
        end
    end

    assign evt_valid   = (count_q != '0);
    assign evt_id      = mem_id_q[rd_ptr_q];
    assign evt_cycle   = mem_cyc_q[rd_ptr_q];
    assign pending     = pending_q;
    assign total_count = total_q;
    assign overflow    = ovf_q;
    assign stop_req    = stop_q;

endmodule

// File: tb/tb_assert_event_collector.sv
// Bench for assert_event_collector: directed scenarios plus random traffic checked against a queue-based model.
module tb_assert_event_collector;

    localparam int NS    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] cyc;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset_n, enable, clear, evt_ready;
    logic [NS-1:0] fire;
    logic          evt_valid, overflow, stop_req;
    logic [2:0]    evt_id;
    logic [31:0]   evt_cycle;
    logic [NS-1:0] pending;
    logic [15:0]   total_count;
    logic          evt_valid_b, overflow_b, stop_req_b;
    logic [2:0]    evt_id_b;
    logic [31:0]   evt_cycle_b;
    logic [NS-1:0] pending_b;
    logic [15:0]   total_count_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assert_event_collector #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .STOP_THRESH(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .fire(fire),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_cycle(evt_cycle),
        .pending(pending), .total_count(total_count), .overflow(overflow), .stop_req(stop_req)
    );

    assert_event_collector #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .STOP_THRESH(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .fire(fire),
        .evt_valid(evt_valid_b), .evt_ready(evt_ready), .evt_id(evt_id_b), .evt_cycle(evt_cycle_b),
        .pending(pending_b), .total_count(total_count_b), .overflow(overflow_b), .stop_req(stop_req_b)
    );

    // Reference model: event queue, unqueued set, saturating integer total.
    logic [31:0]   m_cnt;
    logic [NS-1:0] m_pend, m_unq;
    int            m_total;
    logic          m_ovf, m_stop1, m_stop5;
    ev_t           m_q[$];

    always @(posedge clock) begin : model
        int            gi;
        logic [NS-1:0] f, g;
        if (!reset_n) begin
            m_cnt = 0; m_pend = 0; m_unq = 0; m_total = 0;
            m_ovf = 0; m_stop1 = 0; m_stop5 = 0;
            m_q.delete();
        end else begin
            f  = enable ? fire : '0;
            gi = -1;
            if (m_q.size() < DEPTH)
                for (int i = NS - 1; i >= 0; i--) if (m_unq[i]) gi = i;
            g = (gi >= 0) ? (NS'(1) << gi) : '0;
            if (clear) begin
                m_pend = 0; m_unq = 0; m_total = 0;
                m_ovf = 0; m_stop1 = 0; m_stop5 = 0;
                m_q.delete();
            end else begin
                if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
                if (gi >= 0) m_q.push_back('{id: 3'(gi), cyc: m_cnt});
                m_ovf   = m_ovf | (|(f & m_unq & ~g));
                m_unq   = (m_unq & ~g) | f;
                m_pend  = m_pend | f;
                m_total = m_total + $countones(f);
                if (m_total > 65535) m_total = 65535;
                m_stop1 = m_stop1 | (m_total >= 1);
                m_stop5 = m_stop5 | (m_total >= 5);
            end
            m_cnt = m_cnt + 32'd1;
        end
    end

    function automatic logic [78:0] dut_snap();
        return {evt_valid, evt_valid ? evt_id : 3'd0, evt_valid ? evt_cycle : 32'd0,
                pending, total_count, overflow, stop_req, total_count_b, stop_req_b};
    endfunction

    function automatic logic [78:0] exp_snap();
        ev_t h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        return {m_q.size() != 0, h.id, h.cyc, m_pend, 16'(m_total), m_ovf, m_stop1,
                16'(m_total), m_stop5};
    endfunction

    task automatic test_reset();
        reset_n = 0; enable = 1; clear = 0; fire = '0; evt_ready = 0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({evt_valid, evt_id, evt_cycle, pending, total_count, overflow, stop_req} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b id=%0d cyc=%0d pend=%h tot=%0d ovf=%b stop=%b, want all 0",
                     evt_valid, evt_id, evt_cycle, pending, total_count, overflow, stop_req);
        end
        reset_n = 1;
    endtask

    task automatic test_first_event();
        evt_ready = 0;
        for (int k = 0; k < 20 && m_cnt != 10; k++) @(negedge clock);
        fire = 8'h08;
        @(negedge clock);
        fire = '0;
        n_cmp++;
        if ({evt_valid, pending, total_count, stop_req} !== {1'b0, 8'h08, 16'd1, 1'b1}) begin
            n_err++;
            $display("FAIL first_state: got v=%b pend=%h tot=%0d stop=%b, want v=0 pend=08 tot=1 stop=1",
                     evt_valid, pending, total_count, stop_req);
        end
        @(negedge clock);
        n_cmp++;
        if ({evt_valid, evt_id, evt_cycle} !== {1'b1, 3'd3, 32'd11}) begin
            n_err++;
            $display("FAIL first_event: got v=%b id=%0d cyc=%0d, want v=1 id=3 cyc=11",
                     evt_valid, evt_id, evt_cycle);
        end
    endtask

    task automatic test_multi_source();
        int          ids[$];
        logic [31:0] cycs[$];
        int          want[4] = '{0, 2, 5, 7};
        clear = 1; @(negedge clock); clear = 0;
        evt_ready = 1; fire = 8'hA5;
        @(negedge clock);
        fire = '0;
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (dut_snap() !== exp_snap()) begin
                n_err++;
                $display("FAIL multi_cycle: got %h want %h", dut_snap(), exp_snap());
            end
            if (evt_valid && evt_ready) begin
                ids.push_back(int'(evt_id));
                cycs.push_back(evt_cycle);
            end
            @(negedge clock);
        end
        n_cmp++;
        if (ids.size() != 4) begin
            n_err++;
            $display("FAIL multi_count: got %0d events, want 4", ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ids[i] != want[i] || cycs[i] !== cycs[0] + 32'(i)) begin
                    n_err++;
                    $display("FAIL multi_order[%0d]: got id=%0d cyc=%0d, want id=%0d cyc=%0d",
                             i, ids[i], cycs[i], want[i], cycs[0] + 32'(i));
                end
            end
        end
        n_cmp++;
        if ({total_count, overflow} !== {16'd4, 1'b0}) begin
            n_err++;
            $display("FAIL multi_total: got tot=%0d ovf=%b, want tot=4 ovf=0", total_count, overflow);
        end
    endtask

    task automatic test_backpressure();
        int n_hs = 0;
        clear = 1; @(negedge clock); clear = 0;
        evt_ready = 0;
        for (int p = 0; p < 6; p++) begin
            fire = 8'h02;
            @(negedge clock);
            fire = '0;
            n_cmp++;
            if (dut_snap() !== exp_snap()) begin
                n_err++;
                $display("FAIL bp_pulse%0d: got %h want %h", p, dut_snap(), exp_snap());
            end
            @(negedge clock);
        end
        n_cmp++;
        if ({evt_valid, overflow, pending, total_count} !== {1'b1, 1'b1, 8'h02, 16'd6}) begin
            n_err++;
            $display("FAIL bp_full: got v=%b ovf=%b pend=%h tot=%0d, want v=1 ovf=1 pend=02 tot=6",
                     evt_valid, overflow, pending, total_count);
        end
        evt_ready = 1;
        for (int k = 0; k < 12; k++) begin
            if (evt_valid) begin
                n_hs++;
                n_cmp++;
                if (evt_id !== 3'd1) begin
                    n_err++;
                    $display("FAIL bp_id: got %0d want 1", evt_id);
                end
            end
            @(negedge clock);
        end
        n_cmp++;
        if (n_hs != 5) begin
            n_err++;
            $display("FAIL bp_drain: got %0d events, want 5", n_hs);
        end
    endtask

    task automatic test_held_fire();
        int n_hs = 0;
        clear = 1; @(negedge clock); clear = 0;
        evt_ready = 1; fire = 8'h01;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k == 2) fire = '0;
            n_cmp++;
            if (dut_snap() !== exp_snap()) begin
                n_err++;
                $display("FAIL held_cycle%0d: got %h want %h", k, dut_snap(), exp_snap());
            end
            if (evt_valid && evt_id == 3'd0) n_hs++;
        end
        n_cmp++;
        if (n_hs != 3 || overflow !== 1'b0 || total_count !== 16'd3) begin
            n_err++;
            $display("FAIL held_result: got events=%0d ovf=%b tot=%0d, want 3 0 3", n_hs, overflow, total_count);
        end
    endtask

    task automatic test_enable_clear();
        logic [31:0] cc;
        clear = 1; @(negedge clock); clear = 0;
        enable = 0;
        for (int k = 0; k < 5; k++) begin
            fire = NS'($urandom_range(1, 255));
            @(negedge clock);
        end
        fire = '0; enable = 1;
        n_cmp++;
        if ({evt_valid, pending, total_count, overflow} !== '0) begin
            n_err++;
            $display("FAIL enable_off: got v=%b pend=%h tot=%0d ovf=%b, want all 0",
                     evt_valid, pending, total_count, overflow);
        end
        evt_ready = 0; fire = 8'h07;
        @(negedge clock);
        fire = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (dut_snap() !== exp_snap()) begin
            n_err++;
            $display("FAIL three_queued: got %h want %h", dut_snap(), exp_snap());
        end
        clear = 1; fire = 8'hFF;
        @(negedge clock);
        clear = 0; fire = '0;
        n_cmp++;
        if ({evt_valid, pending, total_count, stop_req} !== '0) begin
            n_err++;
            $display("FAIL clear_state: got v=%b pend=%h tot=%0d stop=%b, want all 0",
                     evt_valid, pending, total_count, stop_req);
        end
        fire = 8'h10; cc = m_cnt;
        @(negedge clock);
        fire = '0;
        @(negedge clock);
        n_cmp++;
        if ({evt_valid, evt_id, evt_cycle} !== {1'b1, 3'd4, cc + 32'd1}) begin
            n_err++;
            $display("FAIL clear_counter: got v=%b id=%0d cyc=%0d, want v=1 id=4 cyc=%0d",
                     evt_valid, evt_id, evt_cycle, cc + 32'd1);
        end
    endtask

    task automatic test_threshold_saturate();
        clear = 1; @(negedge clock); clear = 0;
        evt_ready = 1; fire = 8'hFF;
        @(negedge clock);
        fire = '0;
        n_cmp++;
        if ({total_count_b, stop_req_b, stop_req} !== {16'd8, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL thresh5: got tot=%0d stop5=%b stop1=%b, want tot=8 stop5=1 stop1=1",
                     total_count_b, stop_req_b, stop_req);
        end
        fire = 8'hFF;
        for (int k = 0; k < 9000; k++) begin
            @(negedge clock);
            n_cmp++;
            if (dut_snap() !== exp_snap()) begin
                n_err++;
                $display("FAIL sat_cycle%0d: got %h want %h", k, dut_snap(), exp_snap());
            end
        end
        fire = '0;
        @(negedge clock);
        n_cmp++;
        if ({total_count, total_count_b, overflow} !== {16'hFFFF, 16'hFFFF, 1'b1}) begin
            n_err++;
            $display("FAIL saturate: got tot=%h tot5=%h ovf=%b, want FFFF FFFF 1",
                     total_count, total_count_b, overflow);
        end
    endtask

    task automatic test_random();
        clear = 1; @(negedge clock); clear = 0;
        for (int k = 0; k < 1500; k++) begin
            enable    = ($urandom_range(0, 3) != 0);
            fire      = NS'($urandom) & NS'($urandom) & NS'($urandom);
            evt_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 63) == 0);
            reset_n   = (k != 700);
            @(negedge clock);
            n_cmp++;
            if (dut_snap() !== exp_snap()) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h want %h", k, dut_snap(), exp_snap());
            end
        end
        reset_n = 1; clear = 0; fire = '0; enable = 1;
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_multi_source();
        test_backpressure();
        test_held_fire();
        test_enable_clear();
        test_threshold_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/assert_event_collector.md
# assert_event_collector

Testbench-side collector for assertion monitors. It receives the per-cycle fire pulses emitted by up to NUM_SRC assertion checkers and keeps a sticky per-source record. It serialises one event per cycle into a small FIFO and presents events to a log/trap consumer on a valid/ready port. It also counts total violations and raises a stop request at a programmable threshold. The block sits between the assertion monitors and the simulation harness, so violations are consumed as transactions instead of ending the run with an immediate `$fatal`.

## Interface
- NUM_SRC, 8: number of fire inputs (2..32); ID_W = clog2(NUM_SRC), derived.
- FIFO_DEPTH, 4: event FIFO entries, power of two, at least 2.
- STOP_THRESH, 1: total_count value at which stop_req asserts (1..65535).
- clock  in  1  single clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  gates fire; when low, fire is ignored entirely.
- clear  in  1  synchronous clear of collected state (see Operation).
- fire  in  NUM_SRC  per-source violation pulse, sampled every cycle.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready.
- evt_id  out  ID_W  source index of head event.
- evt_cycle  out  32  cycle-counter value at enqueue of head event.
- pending  out  NUM_SRC  sticky: source has fired since reset/clear.
- total_count  out  16  saturating count of accepted fires.
- overflow  out  1  sticky: a fire was coalesced into an unqueued event.
- stop_req  out  1  sticky: total_count reached STOP_THRESH.

## Operation
- Reset: all outputs are 0. evt_valid=0, evt_id=0, evt_cycle=0, pending=0, total_count=0, overflow=0, stop_req=0. The cycle counter, unqueued vector and FIFO pointers are also 0.
- Cycle counter: 32-bit, increments every cycle after reset and wraps from FFFF_FFFF to 0. clear does not affect it.
- Accepted fires: f = fire & {NUM_SRC{enable}}.
- pending <= pending | f.
- total_count <= min(total_count + popcount(f), 16'hFFFF).
- unqueued vector u:
  - Grant g = one-hot lowest set bit of u, valid only when the FIFO is not full. g is zero if u=0 or the FIFO is full.
  - u <= (u & ~g) | f.
  - On grant, the FIFO pushes {index(g), counter}.
- overflow <= overflow | |(f & u & ~g). A fire on a source whose earlier event is still unqueued is coalesced; nothing is dropped silently. A fire in the same cycle that source is granted re-arms u without setting overflow.
- FIFO: push on grant, pop on evt_valid & evt_ready. Simultaneous push and pop while full is not possible, because full blocks the grant. Simultaneous push and pop at other occupancies keeps the count unchanged. evt_id and evt_cycle are the head entry; they are held stable while evt_valid & ~evt_ready.
- stop_req <= stop_req | (next total_count >= STOP_THRESH).
- clear, when high, takes priority over the fire of the same cycle. The next state is:
  - pending, u, overflow, stop_req, total_count cleared to 0;
  - FIFO flushed, so evt_valid=0 next cycle;
  - fires in the clear cycle discarded.
- Reset mid-operation behaves as clear and also zeroes the counter. A pending handshake is abandoned.

## Timing
- Fire sampled in cycle N:
  - sets u, pending and total_count at the edge ending N;
  - if granted in N+1, evt_valid=1 in N+2 with evt_cycle equal to the counter value during N+1.
- Minimum fire-to-evt_valid latency is 2 cycles. Each additional simultaneous source adds one cycle, served in ascending index order.
- stop_req rises in N+1 for the fire that brings total_count to STOP_THRESH.
- Throughput is one event enqueued and one dequeued per cycle.
- Back-pressure: with the FIFO full, u holds and further fires on those sources set overflow.

## Test plan
- After reset release, pulse fire[3] for one cycle in counter cycle 10. Required: evt_valid in cycle 12 with evt_id=3, evt_cycle=11; pending=8'h08; total_count=1; stop_req=1 (STOP_THRESH=1) from cycle 11.
- fire=8'b1010_0101 for one cycle, evt_ready=1. Required: ids 0,2,5,7 on consecutive cycles; evt_cycle increasing by 1; total_count=4; overflow=0.
- evt_ready=0, fire[1] pulsed 6 times spaced 2 cycles apart (FIFO_DEPTH=4). Required: 4 entries queued; 5th fire holds u[1]; 6th fire sets overflow; releasing evt_ready drains 5 events.
- fire[0] held high continuously for 3 cycles with evt_ready=1. Required: 3 events for id 0; overflow=0; total_count=3.
- Fire with enable=0: no state change. clear while FIFO holds 3 entries: evt_valid=0, pending=0 and total_count=0 next cycle; the counter is unaffected.
- STOP_THRESH=5, fire=all-ones (8 sources) for 1 cycle. Required: total_count=8, stop_req=1 next cycle. Next, 9000 all-ones cycles: total_count saturates at 16'hFFFF.
